// File: rtl/cbus_rx_filter.sv
// cbus_rx_filter: store-and-forward receive filter for the Cbus link.
// Buffers each incoming frame, checks its length and trailing CRC-16/CCITT-FALSE,
// strips the CRC and forwards only good frames on a backpressured AXI-Stream master.
// Failed frames are rolled back whole; every frame produces exactly one status pulse.
module cbus_rx_filter #(
   parameter int DEPTH   = 2048,
   parameter int MIN_LEN = 3,
   parameter int MAX_LEN = 1024
) (
   input  logic       rx_core_clk,
   input  logic       rx_resetn,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   input  logic       s_axis_tlast,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   output logic       m_axis_tlast,
   input  logic       m_axis_tready,
   output logic       stat_ok,
   output logic       stat_crc_err,
   output logic       stat_len_err,
   output logic       stat_ovf
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(MAX_LEN + 2) + 1;
   localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(MAX_LEN + 1);
   localparam logic [CNT_W-1:0]  CNT_MIN  = CNT_W'(MIN_LEN);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_LEN);
   localparam logic [CNT_W-1:0]  CNT_TWO  = CNT_W'(2);
   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RECV,
      S_DROP
   } state_t;

   // Byte-wide CRC-16 update, polynomial 0x1021, MSB first.
   function automatic logic [15:0] crcByte(input logic [15:0] crcIn, input logic [7:0] dataIn);
      logic [15:0] x;
      x = crcIn ^ {dataIn, 8'h00};
      for (int i = 0; i < 8; i++) begin
         x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
      end
      return x;
   endfunction

   state_t            r_state;
   state_t            w_stateNext;
   logic [CNT_W-1:0]  r_count;
   logic [15:0]       r_crc;
   logic [7:0]        r_dly1;
   logic [7:0]        r_dly2;
   logic              r_ovfFlag;
   logic              r_lenFlag;
   logic [ADDR_W:0]   r_wrPtr;
   logic [ADDR_W:0]   r_commitPtr;
   logic [ADDR_W:0]   r_rdPtr;
   logic [8:0]        r_mem [DEPTH];
   logic [7:0]        r_outData;
   logic              r_outLast;
   logic              r_outValid;
   logic              r_statOk;
   logic              r_statCrc;
   logic              r_statLen;
   logic              r_statOvf;

   logic [CNT_W-1:0]  w_countInc;
   logic [15:0]       w_crcNext;
   logic              w_full;
   logic              w_needWrite;
   logic              w_wrEn;
   logic              w_wrLast;
   logic              w_judge;
   logic              w_jOk;
   logic              w_jCrc;
   logic              w_jLen;
   logic              w_jOvf;
   logic              w_setOvf;
   logic              w_setLen;
   logic              w_load;

   assign w_countInc  = (r_count == CNT_SAT) ? r_count : r_count + 1'b1;
   assign w_crcNext   = crcByte(r_crc, s_axis_tdata);
   assign w_full      = (r_wrPtr - r_rdPtr) == FULL_CNT;
   assign w_needWrite = r_count >= CNT_TWO;

   // Receive FSM: decides per accepted byte whether to write the byte two behind it,
   // abandon the frame into DROP, or judge the frame when tlast arrives.
   always_comb begin
      w_stateNext = r_state;
      w_wrEn      = 1'b0;
      w_wrLast    = 1'b0;
      w_judge     = 1'b0;
      w_jOk       = 1'b0;
      w_jCrc      = 1'b0;
      w_jLen      = 1'b0;
      w_jOvf      = 1'b0;
      w_setOvf    = 1'b0;
      w_setLen    = 1'b0;
      case (r_state)
         S_IDLE, S_RECV: begin
            if (s_axis_tvalid) begin
               if (s_axis_tlast) begin
                  w_judge     = 1'b1;
                  w_stateNext = S_IDLE;
                  if (w_needWrite && w_full) begin
                     w_jOvf = 1'b1;
                  end else if ((w_countInc < CNT_MIN) || (w_countInc > CNT_MAX)) begin
                     w_jLen = 1'b1;
                  end else if (w_crcNext != 16'h0000) begin
                     w_jCrc = 1'b1;
                  end else begin
                     w_jOk    = 1'b1;
                     w_wrEn   = 1'b1;
                     w_wrLast = 1'b1;
                  end
               end else if (w_needWrite && w_full) begin
                  w_setOvf    = 1'b1;
                  w_stateNext = S_DROP;
               end else if (w_countInc > CNT_MAX) begin
                  w_setLen    = 1'b1;
                  w_stateNext = S_DROP;
               end else begin
                  w_wrEn      = w_needWrite;
                  w_stateNext = S_RECV;
               end
            end
         end
         S_DROP: begin
            if (s_axis_tvalid && s_axis_tlast) begin
               w_judge     = 1'b1;
               w_jOvf      = r_ovfFlag;
               w_jLen      = ~r_ovfFlag;
               w_stateNext = S_IDLE;
            end
         end
         default: w_stateNext = S_IDLE;
      endcase
   end

   // Receive-side state: FSM register, byte counter, running CRC, 2-byte delay line,
   // drop reasons, write/commit pointers and the registered status pulses.
   always_ff @(posedge rx_core_clk) begin
      if (!rx_resetn) begin
         r_state     <= S_IDLE;
         r_count     <= '0;
         r_crc       <= 16'hFFFF;
         r_dly1      <= 8'h00;
         r_dly2      <= 8'h00;
         r_ovfFlag   <= 1'b0;
         r_lenFlag   <= 1'b0;
         r_wrPtr     <= '0;
         r_commitPtr <= '0;
         r_statOk    <= 1'b0;
         r_statCrc   <= 1'b0;
         r_statLen   <= 1'b0;
         r_statOvf   <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_statOk  <= w_jOk;
         r_statCrc <= w_jCrc;
         r_statLen <= w_jLen;
         r_statOvf <= w_jOvf;
         if (s_axis_tvalid) begin
            r_dly1 <= s_axis_tdata;
            r_dly2 <= r_dly1;
            if (s_axis_tlast) begin
               r_count <= '0;
               r_crc   <= 16'hFFFF;
            end else begin
               r_count <= w_countInc;
               r_crc   <= w_crcNext;
            end
         end
         if (w_judge) begin
            r_ovfFlag <= 1'b0;
            r_lenFlag <= 1'b0;
         end else begin
            if (w_setOvf) r_ovfFlag <= 1'b1;
            if (w_setLen) r_lenFlag <= 1'b1;
         end
         if (w_jOk) begin
            r_wrPtr     <= r_wrPtr + 1'b1;
            r_commitPtr <= r_wrPtr + 1'b1;
         end else if (w_judge) begin
            r_wrPtr <= r_commitPtr;
         end else if (w_wrEn) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
      end
   end

   // Frame buffer write port; the RAM itself carries no reset since the pointers
   // define which entries are meaningful.
   always_ff @(posedge rx_core_clk) begin
      if (w_wrEn) begin
         r_mem[r_wrPtr[ADDR_W-1:0]] <= {w_wrLast, r_dly2};
      end
   end

   // The synchronous RAM read lands directly in the output register, which is
   // refilled whenever it is empty or being drained, giving one byte per cycle.
   assign w_load = (r_rdPtr != r_commitPtr) && (!r_outValid || m_axis_tready);

   // Read side: prefetching output register and read pointer.
   always_ff @(posedge rx_core_clk) begin
      if (!rx_resetn) begin
         r_rdPtr    <= '0;
         r_outData  <= 8'h00;
         r_outLast  <= 1'b0;
         r_outValid <= 1'b0;
      end else if (w_load) begin
         {r_outLast, r_outData} <= r_mem[r_rdPtr[ADDR_W-1:0]];
         r_outValid             <= 1'b1;
         r_rdPtr                <= r_rdPtr + 1'b1;
      end else if (m_axis_tready) begin
         r_outValid <= 1'b0;
      end
   end

   assign m_axis_tdata  = r_outData;
   assign m_axis_tlast  = r_outLast;
   assign m_axis_tvalid = r_outValid;
   assign stat_ok       = r_statOk;
   assign stat_crc_err  = r_statCrc;
   assign stat_len_err  = r_statLen;
   assign stat_ovf      = r_statOvf;

   // The saturating drop flag for length is held only for symmetry with overflow;
   // the DROP judgement derives length from the absence of the overflow flag.
   logic w_unusedLenFlag;
   assign w_unusedLenFlag = r_lenFlag;

endmodule

// File: tb/tb_cbus_rx_filter.sv
// Testbench for cbus_rx_filter: random and directed frames are driven into two
// instances (a full-size one and a 16-byte-buffer one for overflow), expected
// status pulses and payload bytes are queued from a frame-level reference model,
// and monitors compare whatever the DUT presents.
module tb_cbus_rx_filter;

   localparam int MIN_A = 3;
   localparam int MAX_A = 1024;

   logic       rx_core_clk = 1'b0;
   logic       rx_resetn = 1'b0;
   logic [7:0] s_axis_tdata = 8'h00;
   logic       s_axis_tvalid = 1'b0;
   logic       s_axis_tlast = 1'b0;

   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tlast;
   logic       rdyA = 1'b1;
   logic       stat_ok, stat_crc_err, stat_len_err, stat_ovf;

   logic [7:0] bData;
   logic       bValid, bLast;
   logic       rdyB = 1'b1;
   logic       bOk, bCrc, bLen, bOvf;

   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   int         rdyMode = 1;
   int         tlastCyc = 0;
   int         lastStatCyc = -100;
   int         validRiseCyc = -100;
   bit         prevHold = 0;
   bit         prevValid = 0;
   logic [8:0] prevWord = 9'h000;

   logic [7:0] frameBuf[$];
   logic [8:0] expByte[$];
   logic [3:0] expStat[$];
   logic [3:0] bStat[$];
   logic [8:0] bByte[$];

   cbus_rx_filter #(.DEPTH(2048), .MIN_LEN(3), .MAX_LEN(1024)) dutA (
      .rx_core_clk  (rx_core_clk),
      .rx_resetn    (rx_resetn),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast (s_axis_tlast),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast (m_axis_tlast),
      .m_axis_tready(rdyA),
      .stat_ok      (stat_ok),
      .stat_crc_err (stat_crc_err),
      .stat_len_err (stat_len_err),
      .stat_ovf     (stat_ovf)
   );

   cbus_rx_filter #(.DEPTH(16), .MIN_LEN(3), .MAX_LEN(18)) dutB (
      .rx_core_clk  (rx_core_clk),
      .rx_resetn    (rx_resetn),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast (s_axis_tlast),
      .m_axis_tdata (bData),
      .m_axis_tvalid(bValid),
      .m_axis_tlast (bLast),
      .m_axis_tready(rdyB),
      .stat_ok      (bOk),
      .stat_crc_err (bCrc),
      .stat_len_err (bLen),
      .stat_ovf     (bOvf)
   );

   always #5 rx_core_clk = ~rx_core_clk;

   // Cycle counter used for latency measurements.
   always @(posedge rx_core_clk) cyc <= cyc + 1;

   // Downstream ready for the main instance: held high or randomised each cycle.
   initial begin
      forever begin
         @(posedge rx_core_clk);
         #1;
         rdyA = (rdyMode == 1) ? 1'b1 : 1'(($urandom_range(0, 1)));
      end
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference CRC-16/CCITT-FALSE, bit-serial, over the first n bytes of frameBuf.
   function automatic logic [15:0] refCrc(input int n);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         for (int b = 7; b >= 0; b--) begin
            fb = c[15] ^ frameBuf[i][b];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         end
      end
      return c;
   endfunction

   // Frame-level model: length rule first, then trailing CRC compared with payload CRC.
   task automatic pushExpected();
      int          n;
      logic [15:0] c;
      n = frameBuf.size();
      if (n < MIN_A || n > MAX_A) begin
         expStat.push_back(4'b0100);
      end else begin
         c = refCrc(n - 2);
         if (c == {frameBuf[n-2], frameBuf[n-1]}) begin
            expStat.push_back(4'b0001);
            for (int i = 0; i < n - 2; i++) expByte.push_back({1'(i == n - 3), frameBuf[i]});
         end else begin
            expStat.push_back(4'b0010);
         end
      end
   endtask

   task automatic loadRefFrame();
      frameBuf.delete();
      for (int i = 0; i < 9; i++) frameBuf.push_back(8'(8'h31 + i));
      frameBuf.push_back(8'h29);
      frameBuf.push_back(8'hB1);
   endtask

   task automatic makeFrame(input int len, input bit good);
      logic [15:0] c;
      int          p;
      frameBuf.delete();
      if (len < 3) begin
         for (int i = 0; i < len; i++) frameBuf.push_back(8'($urandom));
      end else begin
         for (int i = 0; i < len - 2; i++) frameBuf.push_back(8'($urandom));
         c = refCrc(len - 2);
         frameBuf.push_back(c[15:8]);
         frameBuf.push_back(c[7:0]);
         if (!good) begin
            p = int'($urandom_range(0, len - 1));
            frameBuf[p] = frameBuf[p] ^ 8'(1 << $urandom_range(0, 7));
         end
      end
   endtask

   task automatic idle(input int n);
      for (int g = 0; g < n; g++) begin
         @(posedge rx_core_clk);
         #1;
         s_axis_tvalid = 1'b0;
         s_axis_tlast  = 1'b0;
      end
   endtask

   // Drives frameBuf with no gaps, queues the expected outcome, then idles 'gap' cycles.
   task automatic applyStimulus(input int gap);
      int n;
      n = frameBuf.size();
      for (int i = 0; i < n; i++) begin
         @(posedge rx_core_clk);
         #1;
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = frameBuf[i];
         s_axis_tlast  = (i == n - 1);
      end
      tlastCyc = cyc;
      pushExpected();
      idle(gap);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " tvalid"}, int'(m_axis_tvalid), 0);
      checkOutput({tag, " tdata"}, int'(m_axis_tdata), 0);
      checkOutput({tag, " tlast"}, int'(m_axis_tlast), 0);
      checkOutput({tag, " stat"}, int'({stat_ovf, stat_len_err, stat_crc_err, stat_ok}), 0);
   endtask

   task automatic waitDrain(input string name);
      for (int i = 0; i < 20000; i++) begin
         if (expByte.size() == 0 && expStat.size() == 0) break;
         @(posedge rx_core_clk);
      end
      checkOutput(name, expByte.size() + expStat.size(), 0);
      repeat (3) @(posedge rx_core_clk);
      #1;
   endtask

   task automatic flushAll();
      expByte.delete();
      expStat.delete();
      bStat.delete();
      bByte.delete();
   endtask

   // Monitor for the main instance: pops expected status and payload, checks holds.
   always @(negedge rx_core_clk) begin
      logic [3:0] st;
      logic [8:0] w;
      if (rx_resetn) begin
         st = {stat_ovf, stat_len_err, stat_crc_err, stat_ok};
         w  = {m_axis_tlast, m_axis_tdata};
         if (st != 4'b0000) begin
            lastStatCyc = cyc;
            if (expStat.size() == 0) checkOutput("unexpected stat", int'(st), 0);
            else checkOutput("stat", int'(st), int'(expStat.pop_front()));
         end
         if (m_axis_tvalid && !prevValid) validRiseCyc = cyc;
         if (prevHold) begin
            checkOutput("hold tvalid", int'(m_axis_tvalid), 1);
            checkOutput("hold word", int'(w), int'(prevWord));
         end
         if (m_axis_tvalid && rdyA) begin
            if (expByte.size() == 0) checkOutput("unexpected byte", int'(w), 512);
            else checkOutput("out byte", int'(w), int'(expByte.pop_front()));
         end
         prevHold  = m_axis_tvalid && !rdyA;
         prevWord  = w;
         prevValid = m_axis_tvalid;
      end else begin
         prevHold  = 0;
         prevValid = 0;
      end
   end

   // Capture for the small-buffer instance.
   always @(negedge rx_core_clk) begin
      if (rx_resetn) begin
         if ({bOvf, bLen, bCrc, bOk} != 4'b0000) bStat.push_back({bOvf, bLen, bCrc, bOk});
         if (bValid && rdyB) bByte.push_back({bLast, bData});
      end
   end

   initial begin
      #500000;
      miscompares++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      int len;
      rx_resetn = 1'b0;
      repeat (3) @(posedge rx_core_clk);
      #1;
      checkResetState("reset");
      rx_resetn = 1'b1;
      $display("[TB] reset released");

      // Known good frame "123456789" + 0x29B1 with tready high, latency checked.
      rdyMode = 1;
      idle(2);
      loadRefFrame();
      applyStimulus(6);
      checkOutput("stat latency", lastStatCyc - tlastCyc, 1);
      checkOutput("tvalid latency", validRiseCyc - tlastCyc, 2);

      // Corrupted CRC, then the good frame again to show rollback.
      loadRefFrame();
      frameBuf[10] = 8'hB0;
      applyStimulus(2);
      loadRefFrame();
      applyStimulus(2);

      // Short frames.
      makeFrame(2, 1);
      applyStimulus(2);
      makeFrame(1, 1);
      applyStimulus(2);
      waitDrain("drain after short frames");

      // Oversized frame followed by a good one.
      makeFrame(1100, 1);
      applyStimulus(1);
      loadRefFrame();
      applyStimulus(2);
      waitDrain("drain after long frame");

      // Three back-to-back good frames under random backpressure.
      rdyMode = 0;
      makeFrame(int'($urandom_range(3, 30)), 1);
      applyStimulus(0);
      makeFrame(int'($urandom_range(3, 30)), 1);
      applyStimulus(0);
      makeFrame(int'($urandom_range(3, 30)), 1);
      applyStimulus(3);

      // Random mix of good, corrupted and short frames.
      for (int k = 0; k < 30; k++) begin
         len = int'($urandom_range(1, 40));
         makeFrame(len, $urandom_range(0, 9) < 7);
         applyStimulus(int'($urandom_range(0, 3)));
      end
      idle(1);
      waitDrain("drain after random frames");

      // Reset asserted for one cycle during byte 5 of an 11-byte frame.
      loadRefFrame();
      for (int i = 0; i < 11; i++) begin
         @(posedge rx_core_clk);
         #1;
         if (i == 6) begin
            flushAll();
            checkResetState("mid-frame reset");
            rx_resetn = 1'b1;
         end
         if (i == 5) rx_resetn = 1'b0;
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = frameBuf[i];
         s_axis_tlast  = (i == 10);
      end
      repeat (6) frameBuf.pop_front();
      pushExpected();
      idle(2);
      loadRefFrame();
      applyStimulus(2);
      waitDrain("drain after mid-frame reset");

      // Overflow on the 16-byte instance with its output stalled.
      @(posedge rx_core_clk);
      #1;
      rx_resetn = 1'b0;
      @(posedge rx_core_clk);
      #1;
      rx_resetn = 1'b1;
      flushAll();
      rdyB = 1'b0;
      loadRefFrame();
      applyStimulus(2);
      makeFrame(20, 1);
      applyStimulus(10);
      checkOutput("B stat count", bStat.size(), 2);
      checkOutput("B stat first", (bStat.size() > 0) ? int'(bStat[0]) : -1, 1);
      checkOutput("B stat second", (bStat.size() > 1) ? int'(bStat[1]) : -1, 8);
      rdyB = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (bByte.size() >= 9) break;
         @(posedge rx_core_clk);
      end
      repeat (20) @(posedge rx_core_clk);
      #1;
      checkOutput("B byte count", bByte.size(), 9);
      for (int i = 0; i < 9; i++) begin
         checkOutput($sformatf("B byte %0d", i), (bByte.size() > i) ? int'(bByte[i]) : -1,
                     (i == 8 ? 256 : 0) + 'h31 + i);
      end

      waitDrain("final drain");
      checkOutput("final tvalid", int'(m_axis_tvalid), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cbus_rx_filter.md
# cbus_rx_filter

Store-and-forward receive filter placed directly downstream of the Cbus link's RX AXI-Stream output (no backpressure source). It buffers each incoming frame, verifies length and a trailing CRC-16, strips the CRC, and releases only good frames on a backpressured AXI-Stream master. Bad, oversized or overflowing frames are discarded whole, and a one-cycle status pulse reports the outcome of every frame.

## Interface
- DEPTH, 2048: buffer size in bytes; power of two, ≥16.
- MIN_LEN, 3: minimum frame length in bytes including the 2 CRC bytes; ≥3.
- MAX_LEN, 1024: maximum frame length including CRC; MIN_LEN ≤ MAX_LEN ≤ DEPTH+2.

- rx_core_clk  in  1  sole clock.
- rx_resetn  in  1  synchronous, active-low reset.
- s_axis_tdata  in  8  byte from link.
- s_axis_tvalid  in  1  byte strobe; no tready, every valid byte must be consumed.
- s_axis_tlast  in  1  last byte of frame.
- m_axis_tdata  out  8  payload byte.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  last payload byte.
- m_axis_tready  in  1  downstream ready.
- stat_ok  out  1  pulse: frame committed.
- stat_crc_err  out  1  pulse: CRC mismatch, frame dropped.
- stat_len_err  out  1  pulse: length < MIN_LEN or > MAX_LEN, dropped.
- stat_ovf  out  1  pulse: buffer full during frame, dropped.

## Operation
- Frame = bytes b0..b(N-1), tlast on b(N-1). b(N-2), b(N-1) = CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, MSB-first, no reflection, no xorout) over b0..b(N-3), high byte first. Check by running the CRC over all N bytes; a residue of 0x0000 passes.
- Payload b0..b(N-3) is written to the buffer through a 2-byte delay: b(k-2) is written when b(k) is accepted. When tlast is accepted, b(N-3) is written with its tlast bit set, and the two delayed bytes (CRC) are discarded.
- Buffer: DEPTH×9-bit RAM. Pointers are ADDR_W+1 bits: wr_ptr, commit_ptr, rd_ptr. Full when wr_ptr−rd_ptr == DEPTH.
- Receive FSM:
  - IDLE → RECV on the first valid byte. A 1-byte frame (tlast on that byte) is judged immediately.
  - RECV: count bytes (saturating). When a write is needed and the buffer is full, set ovf and go to DROP. When count exceeds MAX_LEN, set len flag and go to DROP. On tlast, judge the frame and go to IDLE.
  - DROP: no writes; on tlast, go to IDLE.
- Judgement at tlast, exactly one pulse per frame, priority ovf > len > crc > ok.
  - ok: commit_ptr ← wr_ptr.
  - Any failure: wr_ptr ← commit_ptr (rollback).
- Read side: the output is valid while rd_ptr ≠ commit_ptr. RAM is read synchronously into an output register, with prefetch so that a continuously high tready gives 1 byte/cycle.
- Simultaneous read and write in the same cycle are allowed. The full check uses the current rd_ptr; a read in the same cycle does not relieve full until the next cycle.

## Timing
- Reset values: all outputs 0; pointers 0; FSM IDLE; CRC register 0xFFFF; delay line empty.
- Reset mid-frame: the partial frame and all uncommitted and unread data are lost. Bytes arriving after reset release open a new frame, which normally fails CRC or length.
- tlast accepted at cycle T:
  - stat_* pulse at T+1.
  - commit_ptr updated at T+1.
  - Earliest m_axis_tvalid at T+2 when the buffer was otherwise empty.
- AXIS master rules:
  - While tvalid is high and tready is low, tdata, tlast and tvalid hold.
  - Transfer on tvalid & tready.
  - tvalid never depends combinationally on tready.
- Back-to-back input frames with zero idle cycles must be handled. The CRC register and counter re-initialise on the byte after tlast.

## Test plan
- Good frame: 0x31..0x39, 0xB1, 0x29 … use CRC bytes 0x29, 0xB1 (frame 0x31..0x39,0x29,0xB1, N=11), tready=1 → stat_ok at T+1; 9 bytes 0x31..0x39 out, tlast on 0x39, first tvalid at T+2.
- Corrupt CRC: same frame, last byte 0xB0 → stat_crc_err only, no output, wr_ptr returns to prior commit_ptr.
- Length: a 2-byte frame → stat_len_err. A 1100-byte frame with MAX_LEN=1024 → stat_len_err at its tlast; the following good frame passes intact.
- Overflow: DEPTH=16, tready=0; good 11-byte frame commits 9 bytes, then a 20-byte frame arrives → stat_ovf. Then tready=1 → exactly the first frame's 9 bytes out.
- Backpressure: three back-to-back good frames with a random tready pattern → byte-exact, in-order output, tlast at frame ends, no tvalid drop mid-hold.
- Reset mid-frame: rx_resetn low for 1 cycle during byte 5 of 11 → outputs 0 next cycle, no pulse for the aborted frame, the next good frame passes.
